// File: rtl/decode_queue.sv
// RV32I(+M) decode stage feeding a small in-order queue of decoded control words.
// Each accepted instruction is decoded combinationally and stored with its PC.
module decode_queue #(
  parameter bit          ENABLE_M  = 1'b1,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned PC_W      = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  input  logic [PC_W-1:0]                    in_pc,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PC_W-1:0]                    out_pc,
  output logic [4:0]                         out_rs1,
  output logic [4:0]                         out_rs2,
  output logic [4:0]                         out_rd,
  output logic [4:0]                         out_alu_ctrl,
  output logic [2:0]                         out_branch,
  output logic [3:0]                         out_ls_type,
  output logic [2:0]                         out_sext_type,
  output logic [1:0]                         out_wb_ctrl,
  output logic                               out_jump,
  output logic                               out_jump_type,
  output logic                               out_alu_src1,
  output logic                               out_alu_src2,
  output logic                               out_we_reg,
  output logic                               out_we_mem,
  output logic                               out_illegal,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     out_count
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_SRL = 5'b01000;
  localparam logic [4:0] ALU_SRA = 5'b01001;
  localparam logic [4:0] ALU_NOP = 5'b01110;
  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [3:0] LS_NONE = 4'b1111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      alu_ctrl;
    logic [2:0]      branch;
    logic [3:0]      ls_type;
    logic [2:0]      sext_type;
    logic [1:0]      wb_ctrl;
    logic            jump;
    logic            jump_type;
    logic            alu_src1;
    logic            alu_src2;
    logic            we_reg;
    logic            we_mem;
    logic            illegal;
  } entry_t;

  // Control word seen for an empty queue, a bubble and (with illegal set) a bad encoding.
  function automatic entry_t idle_entry();
    entry_t e;
    e           = '0;
    e.alu_ctrl  = ALU_NOP;
    e.branch    = BR_NONE;
    e.ls_type   = LS_NONE;
    return e;
  endfunction

  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    logic [4:0] a;
    case (f3)
      3'b000:  a = ALU_ADD;
      3'b001:  a = 5'b00101;
      3'b010:  a = 5'b00110;
      3'b011:  a = 5'b00111;
      3'b100:  a = 5'b00100;
      3'b101:  a = ALU_SRL;
      3'b110:  a = 5'b00011;
      default: a = 5'b00010;
    endcase
    return a;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  logic       writes_rd;
  entry_t     dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Instruction decode
  always_comb begin
    dec       = idle_entry();
    dec.pc    = in_pc;
    bad       = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_R: begin
        dec.rs1   = in_instr[19:15];
        dec.rs2   = in_instr[24:20];
        dec.rd    = in_instr[11:7];
        writes_rd = 1'b1;
        if (funct7 == F7_BASE) begin
          dec.alu_ctrl = alu_base(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.alu_ctrl = ALU_SRA;
        end else if (funct7 == F7_MUL && ENABLE_M) begin
          dec.alu_ctrl = {2'b10, funct3};
        end else begin
          bad = 1'b1;
        end
      end
      OP_I: begin
        dec.rs1      = in_instr[19:15];
        dec.rd       = in_instr[11:7];
        dec.alu_src2 = 1'b1;
        writes_rd    = 1'b1;
        dec.alu_ctrl = alu_base(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE) bad = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.rs1      = in_instr[19:15];
        dec.rd       = in_instr[11:7];
        dec.alu_ctrl = ALU_ADD;
        dec.alu_src2 = 1'b1;
        dec.ls_type  = {funct3, 1'b0};
        dec.wb_ctrl  = 2'b01;
        writes_rd    = 1'b1;
        bad          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec.rs1       = in_instr[19:15];
        dec.rs2       = in_instr[24:20];
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src2  = 1'b1;
        dec.ls_type   = {funct3, 1'b1};
        dec.sext_type = 3'b110;
        dec.we_mem    = 1'b1;
        bad           = (funct3 >= 3'b011);
      end
      OP_BR: begin
        dec.rs1       = in_instr[19:15];
        dec.rs2       = in_instr[24:20];
        dec.branch    = funct3;
        dec.sext_type = 3'b001;
        bad           = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec.rd        = in_instr[11:7];
        dec.sext_type = 3'b010;
        dec.wb_ctrl   = 2'b11;
        dec.jump      = 1'b1;
        dec.jump_type = 1'b1;
        writes_rd     = 1'b1;
      end
      OP_JALR: begin
        dec.rs1     = in_instr[19:15];
        dec.rd      = in_instr[11:7];
        dec.wb_ctrl = 2'b11;
        dec.jump    = 1'b1;
        writes_rd   = 1'b1;
        bad         = (funct3 != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd        = in_instr[11:7];
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src1  = (opcode == OP_AUIPC);
        dec.alu_src2  = 1'b1;
        dec.sext_type = 3'b011;
        writes_rd     = 1'b1;
      end
      default: bad = (in_instr != 32'h0000_0000);
    endcase
    dec.we_reg = writes_rd && (dec.rd != 5'd0);
    if (bad) begin
      dec         = idle_entry();
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  entry_t            mem_q [BUF_DEPTH];
  entry_t            mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  entry_t            head;

  assign in_ready  = (count_q != CNT_W'(BUF_DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Queue next-state; pointers wrap naturally since BUF_DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) mem_d[wr_ptr_q] = dec;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= idle_entry();
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : idle_entry();

  assign out_pc        = head.pc;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_alu_ctrl  = head.alu_ctrl;
  assign out_branch    = head.branch;
  assign out_ls_type   = head.ls_type;
  assign out_sext_type = head.sext_type;
  assign out_wb_ctrl   = head.wb_ctrl;
  assign out_jump      = head.jump;
  assign out_jump_type = head.jump_type;
  assign out_alu_src1  = head.alu_src1;
  assign out_alu_src2  = head.alu_src2;
  assign out_we_reg    = head.we_reg;
  assign out_we_mem    = head.we_mem;
  assign out_illegal   = head.illegal;
  assign out_count     = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table of encodings with expected control words checked through a
// scoreboard, plus hand sequences for reset, backpressure, flush and pointer wrap.
module tb_decode_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd, alu;
    logic [2:0]  br;
    logic [3:0]  ls;
    logic [2:0]  sext;
    logic [1:0]  wb;
    logic        j, jt, s1, s2, wer, wem, ill;
  } exp_t;

  typedef struct { string nm; logic [31:0] instr; exp_t e; exp_t enm; } vec_t;
  typedef struct { string nm; exp_t e; exp_t enm; } sb_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_ctrl;
  logic [2:0]  out_branch, out_sext_type;
  logic [3:0]  out_ls_type;
  logic [1:0]  out_wb_ctrl, out_count;
  logic        out_jump, out_jump_type, out_alu_src1, out_alu_src2;
  logic        out_we_reg, out_we_mem, out_illegal;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc;
  logic [4:0]  n_out_rs1, n_out_rs2, n_out_rd, n_out_alu_ctrl;
  logic [2:0]  n_out_branch, n_out_sext_type;
  logic [3:0]  n_out_ls_type;
  logic [1:0]  n_out_wb_ctrl, n_out_count;
  logic        n_out_jump, n_out_jump_type, n_out_alu_src1, n_out_alu_src2;
  logic        n_out_we_reg, n_out_we_mem, n_out_illegal;

  always #5 clk = ~clk;

  decode_queue #(.ENABLE_M(1'b1), .BUF_DEPTH(2), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_ctrl(out_alu_ctrl), .out_branch(out_branch), .out_ls_type(out_ls_type),
    .out_sext_type(out_sext_type), .out_wb_ctrl(out_wb_ctrl), .out_jump(out_jump),
    .out_jump_type(out_jump_type), .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
    .out_we_reg(out_we_reg), .out_we_mem(out_we_mem), .out_illegal(out_illegal),
    .out_count(out_count)
  );

  decode_queue #(.ENABLE_M(1'b0), .BUF_DEPTH(2), .PC_W(32)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd),
    .out_alu_ctrl(n_out_alu_ctrl), .out_branch(n_out_branch), .out_ls_type(n_out_ls_type),
    .out_sext_type(n_out_sext_type), .out_wb_ctrl(n_out_wb_ctrl), .out_jump(n_out_jump),
    .out_jump_type(n_out_jump_type), .out_alu_src1(n_out_alu_src1),
    .out_alu_src2(n_out_alu_src2), .out_we_reg(n_out_we_reg), .out_we_mem(n_out_we_mem),
    .out_illegal(n_out_illegal), .out_count(n_out_count)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t vec[$];
  sb_t  sb[$];
  sb_t  cur;

  localparam logic [4:0] ADD = 5'b00000, NOP = 5'b01110;
  localparam logic [2:0] BNT = 3'b010;
  localparam logic [3:0] LSN = 4'b1111;

  function automatic exp_t f(input logic [4:0] rs1, rs2, rd, alu, input logic [2:0] br,
                             input logic [3:0] ls, input logic [2:0] sext, input logic [1:0] wb,
                             input logic j, jt, s1, s2, wer, wem, ill);
    exp_t e;
    e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu; e.br = br; e.ls = ls;
    e.sext = sext; e.wb = wb; e.j = j; e.jt = jt; e.s1 = s1; e.s2 = s2;
    e.wer = wer; e.wem = wem; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t act_m();
    return {out_pc, out_rs1, out_rs2, out_rd, out_alu_ctrl, out_branch, out_ls_type,
            out_sext_type, out_wb_ctrl, out_jump, out_jump_type, out_alu_src1, out_alu_src2,
            out_we_reg, out_we_mem, out_illegal};
  endfunction

  function automatic exp_t act_nm();
    return {n_out_pc, n_out_rs1, n_out_rs2, n_out_rd, n_out_alu_ctrl, n_out_branch,
            n_out_ls_type, n_out_sext_type, n_out_wb_ctrl, n_out_jump, n_out_jump_type,
            n_out_alu_src1, n_out_alu_src2, n_out_we_reg, n_out_we_mem, n_out_illegal};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] instr, input exp_t e, input bit is_m);
    exp_t ill;
    vec_t v;
    ill = f(0, 0, 0, NOP, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    v.nm = nm; v.instr = instr; v.e = e; v.enm = is_m ? ill : e;
    vec.push_back(v);
  endtask

  task automatic drive(input int idx, input logic [31:0] pc);
    in_valid   = 1'b1;
    in_instr   = vec[idx].instr;
    in_pc      = pc;
    cur.nm     = vec[idx].nm;
    cur.e      = vec[idx].e;
    cur.e.pc   = pc;
    cur.enm    = vec[idx].enm;
    cur.enm.pc = pc;
  endtask

  // Pop-compare the head if it is consumed this cycle, record any push, then advance one clock.
  task automatic tick();
    sb_t s;
    if (out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_underflow: got head pc %h expected empty queue", out_pc);
      end else begin
        s = sb.pop_front();
        chk_w({s.nm, "_m1"}, act_m(), s.e);
        chk_w({s.nm, "_m0"}, act_nm(), s.enm);
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t ill, bub;
    ill = f(0, 0, 0, NOP, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    bub = f(0, 0, 0, NOP, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add("addi",     32'h00500093, f(0, 0, 1, ADD, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 1, 1, 0, 0), 0);
    add("mul",      32'h022081B3, f(1, 2, 3, 5'b10000, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0), 1);
    add("lw",       32'h0040A103, f(1, 0, 2, ADD, BNT, 4'b0100, 3'b000, 2'b01, 0, 0, 0, 1, 1, 0, 0), 0);
    add("ld_f3_3",  32'h0040B103, ill, 0);
    add("sub",      32'h407302B3, f(6, 7, 5, 5'b00001, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0), 0);
    add("sw",       32'h00732423, f(6, 7, 0, ADD, BNT, 4'b0101, 3'b110, 2'b00, 0, 0, 0, 1, 0, 1, 0), 0);
    add("bne",      32'h00209463, f(1, 2, 0, NOP, 3'b001, LSN, 3'b001, 2'b00, 0, 0, 0, 0, 0, 0, 0), 0);
    add("jal",      32'h010000EF, f(0, 0, 1, NOP, BNT, LSN, 3'b010, 2'b11, 1, 1, 0, 0, 1, 0, 0), 0);
    add("jalr_f3",  32'h00009067, ill, 0);
    add("lui",      32'h12345237, f(0, 0, 4, ADD, BNT, LSN, 3'b011, 2'b00, 0, 0, 0, 1, 1, 0, 0), 0);
    add("auipc",    32'h00001297, f(0, 0, 5, ADD, BNT, LSN, 3'b011, 2'b00, 0, 0, 1, 1, 1, 0, 0), 0);
    add("srai",     32'h4034D413, f(9, 0, 8, 5'b01001, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 1, 1, 0, 0), 0);
    add("slli_f7",  32'h40349413, ill, 0);
    add("sll_f7",   32'h40209033, ill, 0);
    add("br_f3_2",  32'h0020A463, ill, 0);
    add("st_f3_3",  32'h00733423, ill, 0);
    add("bad_op",   32'h0000007F, ill, 0);
    add("bubble",   32'h00000000, bub, 0);
    add("add_x0",   32'h00208033, f(1, 2, 0, ADD, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0), 0);
    add("sltu",     32'h00C5B533, f(11, 12, 10, 5'b00111, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0), 0);
    add("remu",     32'h023170B3, f(2, 3, 1, 5'b10111, BNT, LSN, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0), 1);

    // Reset held with a valid input present
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(0, 32'h0000_0100);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk_w("rst_idle_head", act_m(), bub);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_push", int'(out_count), 0);

    // Every table entry streams through with out_ready=1: one push and one pop per cycle
    for (int i = 0; i < vec.size(); i++) begin
      drive(i, 32'h0000_1000 + 32'(4 * i));
      tick();
      chk($sformatf("stream_valid_%0d", i), int'(out_valid), 1);
      chk($sformatf("stream_count_%0d", i), int'(out_count), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", int'(out_count), 0);
    chk("stream_sb_empty", sb.size(), 0);

    // Backpressure: third push held while full, then ordered drain
    out_ready = 1'b0;
    drive(0, 32'h0000_2000); tick();
    chk("fill_count_1", int'(out_count), 1);
    chk("fill_ready_1", int'(in_ready), 1);
    drive(2, 32'h0000_2004); tick();
    chk("fill_count_2", int'(out_count), 2);
    chk("fill_ready_2", int'(in_ready), 0);
    drive(4, 32'h0000_2008);
    repeat (2) tick();
    chk("fill_held_count", int'(out_count), 2);
    chk("fill_held_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    chk("drain_count_a", int'(out_count), 1);
    tick();
    chk("drain_count_b", int'(out_count), 1);
    in_valid = 1'b0;
    tick();
    chk("drain_count_c", int'(out_count), 0);
    chk("drain_valid_c", int'(out_valid), 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Flush with a full queue and a same-cycle push
    out_ready = 1'b0;
    drive(1, 32'h0000_3000); tick();
    drive(5, 32'h0000_3004); tick();
    chk("pre_flush_count", int'(out_count), 2);
    flush = 1'b1;
    drive(7, 32'h0000_3008); tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", int'(out_count), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    chk_w("flush_idle_head", act_m(), bub);

    // After the flush, several entries pass so both pointers wrap
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i + 9, 32'h0000_4000 + 32'(4 * i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_count", int'(out_count), 0);
    chk("wrap_sb_empty", sb.size(), 0);

    // Asynchronous reset with entries queued clears them without a clock edge
    out_ready = 1'b0;
    drive(2, 32'h0000_5000); tick();
    drive(6, 32'h0000_5004); tick();
    in_valid = 1'b0;
    chk("mid_pre_count", int'(out_count), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(out_count), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(0, 32'h0000_6000); tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_count", int'(out_count), 0);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
